// File: rtl/validador_jogada_pkg.sv
// Shared board definitions for the move validator: geometry, widths and FSM encoding.
package validador_jogada_pkg;

    localparam int SQ_W  = 6;
    localparam int BOARD = 64;
    localparam int CL_W  = 3;
    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        PEDE   = 3'd1,
        ESPERA = 3'd2,
        CHECA  = 3'd3,
        VARRE  = 3'd4,
        ACEITA = 3'd5
    } estado_t;

    // Square index as used by the generator: coluna = Q/8, linha = Q%8.
    function automatic logic [SQ_W-1:0] sq_idx(input logic [CL_W-1:0] col,
                                               input logic [CL_W-1:0] lin);
        return {col, lin};
    endfunction

endpackage

// File: rtl/validador_jogada_mapa_ocupacao.sv
// 64-square occupancy map with a running count of used squares.
module validador_jogada_mapa_ocupacao
    import validador_jogada_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             set_en,
    input  logic [SQ_W-1:0]  set_idx,
    input  logic [SQ_W-1:0]  rd_idx,
    output logic             rd_bit,
    output logic [CNT_W-1:0] usadas
);

    logic [BOARD-1:0] mapa_r;
    logic [CNT_W-1:0] usadas_r;

    // Map and population count; the count only moves when a free bit is marked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mapa_r   <= {BOARD{1'b0}};
            usadas_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            mapa_r   <= {BOARD{1'b0}};
            usadas_r <= {CNT_W{1'b0}};
        end else if (set_en && !mapa_r[set_idx]) begin
            mapa_r[set_idx] <= 1'b1;
            usadas_r        <= usadas_r + 7'd1;
        end else begin
            mapa_r   <= mapa_r;
            usadas_r <= usadas_r;
        end
    end

    assign rd_bit = mapa_r[rd_idx];
    assign usadas = usadas_r;

endmodule

// File: rtl/validador_jogada.sv
// Requester side of the move generator: asks for random squares, rejects used ones,
// and falls back to a linear scan after MAX_TENT rejections.
module validador_jogada
    import validador_jogada_pkg::*;
#(
    parameter int MAX_TENT = 16,
    parameter int TW       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pedido,
    input  logic             limpa,
    input  logic [CL_W-1:0]  coluna_in,
    input  logic [CL_W-1:0]  linha_in,
    output logic             novaJogada,
    output logic [CL_W-1:0]  coluna,
    output logic [CL_W-1:0]  linha,
    output logic             pronto,
    output logic             cheio,
    output logic             erro,
    output logic [CNT_W-1:0] usadas
);

    estado_t          state_r;
    estado_t          state_nxt_s;
    logic [TW-1:0]    tent_r;
    logic [TW-1:0]    tent_inc_s;
    logic             tent_max_s;
    logic [SQ_W-1:0]  ptr_r;
    logic [SQ_W-1:0]  idx_r;
    logic [SQ_W-1:0]  in_idx_s;
    logic [SQ_W-1:0]  rd_idx_s;
    logic             rd_bit_s;
    logic [CL_W-1:0]  coluna_r;
    logic [CL_W-1:0]  linha_r;
    logic             nova_r;
    logic             pronto_r;
    logic             erro_r;
    logic             cheio_s;
    logic             clr_s;
    logic             set_s;
    logic [CNT_W-1:0] usadas_s;

    assign in_idx_s   = sq_idx(coluna_in, linha_in);
    assign tent_inc_s = tent_r + {{(TW-1){1'b0}}, 1'b1};
    assign tent_max_s = (tent_inc_s == TW'(MAX_TENT));
    assign cheio_s    = (usadas_s == 7'd64);
    assign clr_s      = (state_r == OCIOSO) && limpa && !pedido;
    assign set_s      = (state_r == ACEITA);

    // Map read port: the generator's square while checking, the scan pointer otherwise.
    always_comb begin
        rd_idx_s = ptr_r;
        if (state_r == CHECA) begin
            rd_idx_s = in_idx_s;
        end else begin
            rd_idx_s = ptr_r;
        end
    end

    validador_jogada_mapa_ocupacao u_mapa (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr_s),
        .set_en  (set_s),
        .set_idx (idx_r),
        .rd_idx  (rd_idx_s),
        .rd_bit  (rd_bit_s),
        .usadas  (usadas_s)
    );

    // Next-state logic of the request FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            OCIOSO: begin
                if (pedido && !cheio_s) begin
                    state_nxt_s = PEDE;
                end else begin
                    state_nxt_s = OCIOSO;
                end
            end
            PEDE:   state_nxt_s = ESPERA;
            ESPERA: state_nxt_s = CHECA;
            CHECA: begin
                if (!rd_bit_s) begin
                    state_nxt_s = ACEITA;
                end else if (tent_max_s) begin
                    state_nxt_s = VARRE;
                end else begin
                    state_nxt_s = PEDE;
                end
            end
            VARRE: begin
                if (!rd_bit_s) begin
                    state_nxt_s = ACEITA;
                end else begin
                    state_nxt_s = VARRE;
                end
            end
            ACEITA:  state_nxt_s = OCIOSO;
            default: state_nxt_s = OCIOSO;
        endcase
    end

    // State register, attempt counter, scan pointer and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= OCIOSO;
            tent_r   <= {TW{1'b0}};
            ptr_r    <= {SQ_W{1'b0}};
            idx_r    <= {SQ_W{1'b0}};
            coluna_r <= {CL_W{1'b0}};
            linha_r  <= {CL_W{1'b0}};
            nova_r   <= 1'b0;
            pronto_r <= 1'b0;
            erro_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            nova_r   <= (state_nxt_s == PEDE);
            pronto_r <= (state_r == ACEITA);
            erro_r   <= (state_r == OCIOSO) && pedido && cheio_s;
            case (state_r)
                OCIOSO: begin
                    if (pedido && !cheio_s) begin
                        tent_r <= {TW{1'b0}};
                    end
                end
                CHECA: begin
                    idx_r <= in_idx_s;
                    if (rd_bit_s) begin
                        tent_r <= tent_inc_s;
                        if (tent_max_s) begin
                            ptr_r <= {SQ_W{1'b0}};
                        end
                    end
                end
                VARRE: begin
                    if (!rd_bit_s) begin
                        idx_r <= ptr_r;
                    end else begin
                        ptr_r <= ptr_r + 6'd1;
                    end
                end
                ACEITA: begin
                    coluna_r <= idx_r[5:3];
                    linha_r  <= idx_r[2:0];
                end
                default: begin
                    tent_r <= tent_r;
                end
            endcase
        end
    end

    assign novaJogada = nova_r;
    assign coluna     = coluna_r;
    assign linha      = linha_r;
    assign pronto     = pronto_r;
    assign erro       = erro_r;
    assign cheio      = cheio_s;
    assign usadas     = usadas_s;

endmodule

// File: tb/tb_validador_jogada.sv
// Randomised bench for validador_jogada against a set-based model of square selection.
module tb_validador_jogada;

    localparam int MT = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pedido = 1'b0;
    logic       limpa = 1'b0;
    logic [2:0] coluna_in = 3'd0;
    logic [2:0] linha_in = 3'd0;
    logic       novaJogada;
    logic [2:0] coluna;
    logic [2:0] linha;
    logic       pronto;
    logic       cheio;
    logic       erro;
    logic [6:0] usadas;

    validador_jogada #(.MAX_TENT(MT), .TW(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .pedido     (pedido),
        .limpa      (limpa),
        .coluna_in  (coluna_in),
        .linha_in   (linha_in),
        .novaJogada (novaJogada),
        .coluna     (coluna),
        .linha      (linha),
        .pronto     (pronto),
        .cheio      (cheio),
        .erro       (erro),
        .usadas     (usadas)
    );

    initial forever #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    bit occ[64];
    int used = 0;
    int gen_q[$];
    int plan[MT];
    int v_stub;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Generator stub: latches the next planned square on each novaJogada pulse.
    initial forever begin
        @(posedge clock);
        if (novaJogada === 1'b1) begin
            if (gen_q.size() > 0) v_stub = gen_q.pop_front();
            else v_stub = int'($urandom_range(0, 63));
            coluna_in = 3'(v_stub / 8);
            linha_in  = 3'(v_stub % 8);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 64; i++) occ[i] = 1'b0;
        used = 0;
    endtask

    task automatic do_req(input string tag, input bit with_limpa);
        int  e_idx, e_pulses, e_states, f, pulses, cyc;
        bit  found, got_pronto;
        found = 1'b0;
        e_pulses = 0;
        e_idx = 0;
        for (int i = 0; i < MT; i++) begin
            e_pulses++;
            if (!occ[plan[i]]) begin
                e_idx = plan[i];
                found = 1'b1;
                break;
            end
        end
        if (found) begin
            e_states = 3 * e_pulses + 1;
        end else begin
            f = 0;
            while (f < 63 && occ[f]) f++;
            e_idx = f;
            e_states = 3 * MT + (f + 1) + 1;
        end
        gen_q.delete();
        for (int i = 0; i < MT; i++) gen_q.push_back(plan[i]);
        @(negedge clock);
        pedido = 1'b1;
        limpa  = with_limpa;
        @(negedge clock);
        pedido = 1'b0;
        limpa  = 1'b0;
        cyc = 1;
        pulses = 0;
        got_pronto = 1'b0;
        while (cyc < 200 && !got_pronto) begin
            if (novaJogada) pulses++;
            if (pronto) got_pronto = 1'b1;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        chk($sformatf("%s_pronto", tag), int'(got_pronto), 1);
        chk($sformatf("%s_cycle", tag), cyc, e_states + 1);
        chk($sformatf("%s_pulses", tag), pulses, e_pulses);
        chk($sformatf("%s_coluna", tag), int'(coluna), e_idx / 8);
        chk($sformatf("%s_linha", tag), int'(linha), e_idx % 8);
        chk($sformatf("%s_usadas", tag), int'(usadas), used + 1);
        occ[e_idx] = 1'b1;
        used++;
        @(negedge clock);
        chk($sformatf("%s_pronto_pulse", tag), int'(pronto), 0);
        gen_q.delete();
    endtask

    task automatic check_idle_zero(input string tag);
        chk($sformatf("%s_nova", tag), int'(novaJogada), 0);
        chk($sformatf("%s_pronto", tag), int'(pronto), 0);
        chk($sformatf("%s_erro", tag), int'(erro), 0);
        chk($sformatf("%s_coluna", tag), int'(coluna), 0);
        chk($sformatf("%s_linha", tag), int'(linha), 0);
        chk($sformatf("%s_usadas", tag), int'(usadas), 0);
        chk($sformatf("%s_cheio", tag), int'(cheio), 0);
        chk($sformatf("%s_mapa", tag), int'(dut.u_mapa.mapa_r != 64'd0), 0);
    endtask

    task automatic random_plan();
        for (int i = 0; i < MT; i++) plan[i] = int'($urandom_range(0, 63));
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clock);
        check_idle_zero("reset");
        reset = 1'b1;

        // single request, then a collision followed by a free square
        random_plan();
        plan[0] = 29;
        do_req("single", 1'b0);
        chk("single_mapa29", int'(dut.u_mapa.mapa_r[29]), 1);
        random_plan();
        plan[0] = 29;
        plan[1] = 2;
        do_req("retry", 1'b0);

        // fresh board, squares 0..9 taken, generator stuck on 0 -> scan to 10
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < MT; i++) plan[i] = k;
            do_req("prefill", 1'b0);
        end
        for (int i = 0; i < MT; i++) plan[i] = 0;
        do_req("scan", 1'b0);

        while (used < 64) begin
            random_plan();
            do_req("fill", 1'b0);
        end
        chk("full_cheio", int'(cheio), 1);
        chk("full_usadas", int'(usadas), 64);

        // request on a full board
        @(negedge clock);
        pedido = 1'b1;
        @(negedge clock);
        pedido = 1'b0;
        chk("full_erro", int'(erro), 1);
        chk("full_nova", int'(novaJogada), 0);
        @(negedge clock);
        chk("full_erro_pulse", int'(erro), 0);
        for (int i = 0; i < 6; i++) begin
            chk("full_idle_nova", int'(novaJogada), 0);
            chk("full_idle_pronto", int'(pronto), 0);
            @(negedge clock);
        end

        // limpa alone clears, limpa with pedido is ignored
        limpa = 1'b1;
        @(negedge clock);
        limpa = 1'b0;
        model_clear();
        chk("clr_usadas", int'(usadas), 0);
        chk("clr_cheio", int'(cheio), 0);
        random_plan();
        do_req("post_clr", 1'b0);
        random_plan();
        do_req("prio", 1'b1);

        // reset while waiting on the generator
        gen_q.delete();
        @(negedge clock);
        pedido = 1'b1;
        @(negedge clock);
        pedido = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle_zero("midrst");
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        random_plan();
        plan[0] = 29;
        do_req("after_rst", 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/validador_jogada.md
Name: validador_jogada

Overview:
- Consumer/requester end of the move-generator interface.
- Pulses novaJogada toward the pseudo-random square generator, samples the returned coluna/linha, and rejects squares already used.
- Keeps a 64-bit occupancy map and retries up to MAX_TENT times. After that, falls back to a linear scan so a free square is always delivered while one exists.
- Sits between the game-control FSM (pedido/pronto handshake) and the generator.

Parameters:
- MAX_TENT, 16: random attempts before falling back to linear scan (1..255).
- TW, 8: width of the attempt counter; must hold MAX_TENT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- pedido  in  1  single-cycle request for a new free square; sampled only in OCIOSO.
- limpa  in  1  synchronous clear of the occupancy map; honoured only in OCIOSO.
- coluna_in  in  3  column from the generator.
- linha_in  in  3  row from the generator.
- novaJogada  out  1  registered one-cycle pulse to the generator, which latches on its rising edge.
- coluna  out  3  accepted column; held until the next accept.
- linha  out  3  accepted row; held until the next accept.
- pronto  out  1  one-cycle pulse: coluna/linha now valid.
- cheio  out  1  level: all 64 squares occupied.
- erro  out  1  one-cycle pulse: pedido while cheio.
- usadas  out  7  number of occupied squares (0..64).

Behaviour:
- Square index = coluna*8 + linha (6 bits). This matches the generator: coluna = Q/8, linha = Q%8. mapa[index] = 1 means used.
- Reset (reset = 0, asynchronous): FSM to OCIOSO; mapa = 0; usadas = 0; outputs novaJogada, pronto, erro = 0; coluna = 0; linha = 0; tentativas = 0.
- cheio is combinational: (usadas == 64).
- FSM states:
  - OCIOSO:
    - pedido & cheio: pulse erro next cycle, stay in OCIOSO.
    - pedido & !cheio: tentativas = 0, go to PEDE.
    - limpa & !pedido: mapa = 0, usadas = 0.
    - pedido and limpa in the same cycle: pedido wins; limpa is ignored.
  - PEDE: novaJogada = 1 for exactly this cycle, then go to ESPERA.
  - ESPERA: one idle cycle so the generator output settles after its edge, then go to CHECA.
  - CHECA: sample coluna_in/linha_in and form idx.
    - mapa[idx] == 0: go to ACEITA.
    - Else tentativas += 1. If tentativas == MAX_TENT, set ptr = 0 and go to VARRE; otherwise go to PEDE.
  - VARRE: test mapa[ptr], one index per cycle.
    - Free: idx = ptr, go to ACEITA.
    - Else ptr += 1.
    - ptr is 6-bit. Wrap cannot occur because !cheio guarantees a free bit. Worst case is 64 cycles.
  - ACEITA:
    - mapa[idx] = 1; usadas += 1.
    - Register coluna = idx[5:3], linha = idx[2:0].
    - Pulse pronto for 1 cycle, return to OCIOSO.
- Latency:
  - Best case from pedido to pronto is 4 cycles (PEDE, ESPERA, CHECA, ACEITA) → pronto high in cycle 5.
  - Each rejection adds 3 cycles.
  - The scan adds 1 to 64 cycles.
- pedido arriving outside OCIOSO is ignored, with no queueing. The controller must wait for pronto or erro.
- limpa outside OCIOSO is ignored.
- Reset asserted mid-operation aborts immediately and does not mark the map. novaJogada deasserts asynchronously.
- coluna_in/linha_in are treated as stable and synchronous to clock. No input synchronizer is required.

Decomposition:
- Shared package/header (chess_defs):
  - square-index width (6);
  - board-size constant (64);
  - coluna/linha width (3);
  - FSM state encoding localparams: OCIOSO, PEDE, ESPERA, CHECA, VARRE, ACEITA.
- One natural sub-module, mapa_ocupacao. It holds:
  - 64-bit register with async active-low reset;
  - synchronous clear;
  - set-bit port;
  - combinational read port;
  - population counter usadas.
- FSM and attempt counter stay in validador_jogada.

Test Plan:
- Reset and single request:
  - Stimulus: generator stub returns (3,5); pedido.
  - Response: novaJogada one pulse; pronto in cycle 5 with coluna = 3, linha = 5; usadas = 1; mapa[29] = 1.
- Collision retry:
  - Stimulus: after the case above, stub returns (3,5) then (0,2).
  - Response: exactly two novaJogada pulses; pronto with (0,2); usadas = 2; total latency 7 cycles.
- Fallback scan:
  - Stimulus: MAX_TENT = 4, pre-fill squares 0..9, stub always returns (0,0).
  - Response: 4 pulses, then scan; pronto with coluna = 1, linha = 2 (index 10).
- Full board:
  - Stimulus: 64 successful requests, then one more pedido.
  - Response: cheio = 1 and usadas = 64; erro one-cycle pulse; no novaJogada; pronto stays 0.
- Clear and priority:
  - limpa alone in OCIOSO → usadas = 0, cheio = 0.
  - pedido and limpa in the same cycle → request proceeds and usadas is not cleared.
- Reset mid-operation:
  - Stimulus: assert reset during ESPERA.
  - Response: all outputs zero immediately (asynchronous); mapa = 0; a later pedido behaves as in the first scenario.
